// File: rtl/pwm_capture.sv
// pwm_capture: receive-side decoder for the PWM DAC generator.
// Measures the high time of each 2^COUNTER_WIDTH-clock frame, aligned to the
// generator's frame-start rising edge. It removes the mid-scale offset and emits
// one saturated, sign-extended sample per frame with a one-cycle valid strobe.
module pwm_capture #(
    parameter int DATA_WIDTH    = 10,
    parameter int COUNTER_WIDTH = 10,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  PWMIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  Locked
);

    localparam int HALF = 2 ** (COUNTER_WIDTH - 1);

    localparam logic [0:0] ST_SEARCH  = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [COUNTER_WIDTH-1:0]        FC_LAST  = '1;
    localparam logic signed [COUNTER_WIDTH+1:0] OFFSET   = (COUNTER_WIDTH + 2)'(HALF + 1);
    localparam logic signed [COUNTER_WIDTH+1:0] SAT_MIN  = (COUNTER_WIDTH + 2)'(-HALF);

    logic [SYNC_STAGES-1:0]          sync_q;
    logic                            s;
    logic                            s_prev;
    logic                            rise;
    logic [0:0]                      state;
    logic [COUNTER_WIDTH-1:0]        fc;
    logic [COUNTER_WIDTH:0]          acc;
    logic [COUNTER_WIDTH:0]          total;
    logic signed [COUNTER_WIDTH+1:0] diff;
    logic signed [COUNTER_WIDTH-1:0] sat_val;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

    // Synchronize the asynchronous input and keep a one-cycle-old copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // so the shift chain moves exactly one stage per clock.
            sync_q <= {sync_q[SYNC_STAGES-2:0], PWMIn};
            s_prev <= s;
        end
    end

    assign total = acc + (COUNTER_WIDTH + 1)'(s);
    assign diff  = $signed({1'b0, total}) - OFFSET;

    // Remove the mid-scale offset; only an all-low frame falls below the range.
    always_comb begin
        // NOTE: both branches assign sat_val, so no latch is inferred.
        if (diff < SAT_MIN) begin
            sat_val = SAT_MIN[COUNTER_WIDTH-1:0];
        end else begin
            sat_val = diff[COUNTER_WIDTH-1:0];
        end
    end

    // Frame alignment, high-time accumulation and sample output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            fc        <= '0;
            acc       <= '0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            Locked    <= 1'b0;
        end else begin
            DataValid <= 1'b0;
            if (!enable) begin
                state  <= ST_SEARCH;
                Locked <= 1'b0;
            end else begin
                case (state)
                    ST_SEARCH: begin
                        if (rise) begin
                            fc    <= COUNTER_WIDTH'(1);
                            acc   <= (COUNTER_WIDTH + 1)'(1);
                            state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise && (fc != '0)) begin
                            // Edge inside a frame: restart the frame at this edge, drop the partial.
                            fc     <= COUNTER_WIDTH'(1);
                            acc    <= (COUNTER_WIDTH + 1)'(1);
                            Locked <= 1'b0;
                        end else if (fc == FC_LAST) begin
                            fc        <= '0;
                            acc       <= '0;
                            DataValid <= 1'b1;
                            DataOut   <= DATA_WIDTH'(sat_val);
                            Locked    <= 1'b1;
                        end else begin
                            fc  <= fc + COUNTER_WIDTH'(1);
                            acc <= total;
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM-generator stimulus checked against a frame-level
// model every cycle, plus literal expectations for samples, latency and reset.
module tb_pwm_capture;

    localparam int CW   = 10;
    localparam int DW   = 10;
    localparam int SYNC = 2;
    localparam int N    = 1 << CW;
    localparam int HALF = N / 2;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          pwm_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          locked;

    pwm_capture #(
        .DATA_WIDTH   (DW),
        .COUNTER_WIDTH(CW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .PWMIn    (pwm_in),
        .DataOut  (data_out),
        .DataValid(data_valid),
        .Locked   (locked)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit check_en = 0;
    int samp_val[$];
    int samp_t[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: remembers where the current frame began and the
    // synchronized level at every frame position, then counts highs at frame end.
    bit mp[SYNC];
    bit m_sprev, m_meas, m_s, m_rise;
    int m_cyc, m_start, m_pos, m_total;
    bit m_bits[N];
    logic exp_valid, exp_locked;
    int exp_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mp[i]) mp[i] = 1'b0;
            m_sprev    = 1'b0;
            m_meas     = 1'b0;
            m_cyc      = 0;
            m_start    = 0;
            exp_valid  = 1'b0;
            exp_locked = 1'b0;
            exp_data   = 0;
        end else begin
            m_s       = mp[SYNC-1];
            m_rise    = m_s && !m_sprev;
            m_pos     = (m_cyc - m_start) % N;
            exp_valid = 1'b0;
            if (!enable) begin
                m_meas     = 1'b0;
                exp_locked = 1'b0;
            end else if (m_rise && (!m_meas || m_pos != 0)) begin
                m_meas     = 1'b1;
                exp_locked = 1'b0;
                m_start    = m_cyc;
                m_bits[0]  = 1'b1;
            end else if (m_meas) begin
                m_bits[m_pos] = m_s;
                if (m_pos == N - 1) begin
                    m_total = 0;
                    foreach (m_bits[i]) m_total += int'(m_bits[i]);
                    exp_data = m_total - 1 - HALF;
                    if (exp_data < -HALF) exp_data = -HALF;
                    exp_valid  = 1'b1;
                    exp_locked = 1'b1;
                end
            end
            for (int i = SYNC - 1; i > 0; i--) mp[i] = mp[i-1];
            mp[0]   = pwm_in;
            m_sprev = m_s;
            m_cyc++;
        end
    end

    // Compare every cycle away from the active edge and log each strobe.
    always @(negedge clk) begin
        if (check_en) begin
            check("valid",  int'(data_valid), int'(exp_valid));
            check("locked", int'(locked), int'(exp_locked));
            check("data",   int'($signed(data_out)), exp_data);
        end
        if (rst_n && data_valid) begin
            samp_val.push_back(int'($signed(data_out)));
            samp_t.push_back(cyc);
        end
    end

    task automatic step(input bit p, input bit e);
        @(posedge clk);
        #1;
        pwm_in = p;
        enable = e;
    endtask

    // Generator: frames of N clocks, high for DataIn + N/2 + 1 clocks from frame start.
    task automatic gen(input int d, input int nframes, output int t0);
        int h;
        h  = d + HALF + 1;
        t0 = 0;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < N; i++) begin
                step(i < h, 1'b1);
                if (f == 0 && i == 0) t0 = cyc;
            end
        end
    endtask

    int exp_samples[17] = '{0, 0, 0, -512, -512, 511, 511, 100,
                            -512, -512, 100, 100, 100, 100, 100, 0, 0};
    int t_b, t_inj, t_f, tmp;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Stuck low from reset: never leaves SEARCH.
        repeat (300) step(1'b0, 1'b1);
        check("idle_samples", samp_val.size(), 0);
        check("idle_locked", int'(locked), 0);

        // Locked stream through mid-scale, minimum and maximum codes.
        gen(0, 3, t_b);
        gen(-512, 2, tmp);
        gen(511, 2, tmp);
        gen(100, 1, tmp);

        // Input forced low: all-low frames saturate.
        repeat (2 * N + 10) step(1'b0, 1'b1);

        // Relock (misaligned edge), then an extra edge at frame position 300.
        gen(100, 2, tmp);
        for (int i = 0; i < 300; i++) step(i < 298, 1'b1);
        gen(100, 2, t_inj);

        // Enable low for 5 cycles mid-frame, re-enabled with the input already high.
        for (int i = 0; i < N; i++) begin
            step(i < 613, !(i >= 400 && i < 405));
            if (i == 404) begin
                check("disabled_hold_data", int'($signed(data_out)), 100);
                check("disabled_locked", int'(locked), 0);
            end
        end
        check("disabled_frame_samples", samp_val.size(), 14);
        gen(100, 1, tmp);

        // Asynchronous reset mid-frame, in the low part of the frame.
        for (int i = 0; i < N; i++) begin
            step(i < 513, 1'b1);
            if (i == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_data", int'(data_out), 0);
                check("async_rst_valid", int'(data_valid), 0);
                check("async_rst_locked", int'(locked), 0);
            end
            if (i == 703) rst_n = 1'b1;
        end
        gen(0, 2, t_f);
        repeat (10) step(1'b0, 1'b1);

        check("sample_count", samp_val.size(), 17);
        if (samp_val.size() == 17) begin
            foreach (exp_samples[i]) check($sformatf("sample_%0d", i), samp_val[i], exp_samples[i]);
            check("lat_first_lock", samp_t[0] - t_b, N + SYNC);
            check("period", samp_t[1] - samp_t[0], N);
            check("lat_after_inject", samp_t[12] - t_inj, N + SYNC);
            check("lat_after_reset", samp_t[15] - t_f, N + SYNC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
